// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// State encoding and default operand width.
package mult_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/operand request and product/status response bundle
// between the MULT path controller and the multiplier.
interface seq_multiplier_if
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;

    modport master (
        output start, op_a, op_b,
        input  busy, done, hi, lo, zero
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, hi, lo, zero
    );

endinterface

// File: rtl/seq_multiplier_zero_detect_w.sv
// NOR over a 2*WIDTH-bit value, reduced through repeated
// levels of eight-input OR cells.
module zero_detect_w
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] value,
    output logic               zero
);

    localparam int N = 2 * WIDTH;

    function automatic int tree_levels(input int n);
        int k;
        int l;
        k = n;
        l = 0;
        while (k > 1) begin
            k = (k + 7) / 8;
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = tree_levels(N);

    logic [N-1:0] cur;
    logic [N-1:0] nxt;

    // Each level packs its OR results into the low bits; the
    // zero padding above them is harmless to later OR cells.
    always_comb begin
        cur = value;
        nxt = '0;
        for (int l = 0; l < LEVELS; l++) begin
            nxt = '0;
            for (int i = 0; i < N / 8; i++) begin
                nxt[i] = |cur[8*i +: 8];
            end
            cur = nxt;
        end
        zero = ~cur[0];
    end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one multiplier bit per
// clock, registered HI/LO product and zero flag.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_multiplier_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     upper;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               zero_q;
    logic               acc_zero;
    logic               accept;
    logic               last;

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (count == CW'(WIDTH - 1));

    // Carry out of the upper-half add lands in bit 2W-1.
    always_comb begin
        upper = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            upper = upper + {1'b0, mcand};
        end
        acc_nxt = {upper, acc[WIDTH-1:1]};
    end

    zero_detect_w #(
        .WIDTH (WIDTH)
    ) u_zero (
        .value (acc_nxt),
        .zero  (acc_zero)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = bus.start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            count  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            zero_q <= 1'b1;
        end else if (accept) begin
            mcand <= bus.op_a;
            acc   <= {{WIDTH{1'b0}}, bus.op_b};
            count <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            count <= count + 1'b1;
            if (last) begin
                hi_q   <= acc_nxt[2*WIDTH-1:WIDTH];
                lo_q   <= acc_nxt[WIDTH-1:0];
                zero_q <= acc_zero;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.zero = zero_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: latency, products,
// ignored starts, back-to-back and mid-run reset.
module tb_seq_multiplier;
    import mult_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int chk = 0;
    int pass = 0;
    int cyc;
    int busy_cyc;
    bit to;
    bit both;
    bit lo_moved;

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
    endtask

    // Edges are counted from the one that samples start (cyc=1).
    task automatic wait_done(input int inj_at,
                             input logic [W-1:0] ia,
                             input logic [W-1:0] ib);
        logic [W-1:0] lo0;
        lo0 = bus.lo;
        cyc = 0;
        busy_cyc = 0;
        to = 0;
        both = 0;
        lo_moved = 0;
        while (1) begin
            @(posedge clk);
            cyc++;
            #1;
            bus.start = 1'b0;
            if (cyc == 2) begin
                bus.op_a = $urandom;
                bus.op_b = $urandom;
            end
            if (cyc == inj_at) begin
                bus.start = 1'b1;
                bus.op_a  = ia;
                bus.op_b  = ib;
            end
            if (bus.busy && bus.done) both = 1;
            if (bus.busy) busy_cyc++;
            if (!bus.done && bus.lo !== lo0) lo_moved = 1;
            if (bus.done) break;
            if (cyc >= 100) begin
                to = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk++;
        if ({bus.busy, bus.done, bus.zero} !== 3'b001)
            $display("FAIL reset_flags got busy=%b done=%b zero=%b exp 0 0 1",
                     bus.busy, bus.done, bus.zero);
        else pass++;
        chk++;
        if ({bus.hi, bus.lo} !== 64'd0)
            $display("FAIL reset_prod got %h_%h exp 0", bus.hi, bus.lo);
        else pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk++;
        if ({bus.busy, bus.done, bus.zero} !== 3'b001)
            $display("FAIL idle_flags got busy=%b done=%b zero=%b exp 0 0 1",
                     bus.busy, bus.done, bus.zero);
        else pass++;
    endtask

    task automatic test_basic;
        launch(32'd7, 32'd6);
        wait_done(0, '0, '0);
        chk++;
        if (to || cyc != 33)
            $display("FAIL basic_latency got %0d exp 33 (timeout=%0d)", cyc, to);
        else pass++;
        chk++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd42)
            $display("FAIL basic_prod got %h_%h exp 0_2a", bus.hi, bus.lo);
        else pass++;
        chk++;
        if (bus.zero !== 1'b0)
            $display("FAIL basic_zero got %b exp 0", bus.zero);
        else pass++;
        chk++;
        if (busy_cyc != 32 || both)
            $display("FAIL basic_busy got %0d busy cycles overlap=%0d exp 32 0",
                     busy_cyc, both);
        else pass++;
        chk++;
        if (lo_moved)
            $display("FAIL basic_hold got early lo change exp none");
        else pass++;
    endtask

    task automatic test_max;
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, '0, '0);
        chk++;
        if (to || cyc != 33)
            $display("FAIL max_latency got %0d exp 33", cyc);
        else pass++;
        chk++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001)
            $display("FAIL max_prod got %h_%h exp fffffffe_00000001",
                     bus.hi, bus.lo);
        else pass++;
    endtask

    task automatic test_zero;
        int extra;
        launch(32'h1234_5678, 32'd0);
        wait_done(0, '0, '0);
        chk++;
        if (to || bus.hi !== 32'd0 || bus.lo !== 32'd0)
            $display("FAIL zero_prod got %h_%h exp 0", bus.hi, bus.lo);
        else pass++;
        chk++;
        if (bus.zero !== 1'b1)
            $display("FAIL zero_flag got %b exp 1", bus.zero);
        else pass++;
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
        end
        chk++;
        if (extra != 0 || bus.zero !== 1'b1)
            $display("FAIL zero_once got %0d extra dones zero=%b exp 0 1",
                     extra, bus.zero);
        else pass++;
    endtask

    task automatic test_busy_start;
        int extra;
        launch(32'd100, 32'd200);
        wait_done(10, 32'd3, 32'd3);
        chk++;
        if (to || cyc != 33)
            $display("FAIL busy_latency got %0d exp 33", cyc);
        else pass++;
        chk++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd20000)
            $display("FAIL busy_prod got %h_%h exp 0_4e20", bus.hi, bus.lo);
        else pass++;
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) extra++;
        end
        chk++;
        if (extra != 0 || bus.lo !== 32'd20000)
            $display("FAIL busy_ignored got %0d extra cycles lo=%0d exp 0 20000",
                     extra, bus.lo);
        else pass++;
    endtask

    task automatic test_back_to_back;
        launch(32'd9, 32'd11);
        wait_done(0, '0, '0);
        chk++;
        if (to || bus.lo !== 32'd99)
            $display("FAIL b2b_first got %0d exp 99", bus.lo);
        else pass++;
        bus.start = 1'b1;
        bus.op_a  = 32'd2;
        bus.op_b  = 32'd5;
        wait_done(0, '0, '0);
        chk++;
        if (to || cyc != 33)
            $display("FAIL b2b_latency got %0d exp 33", cyc);
        else pass++;
        chk++;
        if (busy_cyc != 32)
            $display("FAIL b2b_busy got %0d exp 32", busy_cyc);
        else pass++;
        chk++;
        if (lo_moved)
            $display("FAIL b2b_hold got early lo change exp 99 held");
        else pass++;
        chk++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd10)
            $display("FAIL b2b_prod got %h_%h exp 0_a", bus.hi, bus.lo);
        else pass++;
    endtask

    task automatic test_reset_mid_run;
        launch(32'd7, 32'd6);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk++;
        if (bus.busy !== 1'b1)
            $display("FAIL rst_pre_busy got %b exp 1", bus.busy);
        else pass++;
        rst_n = 1'b0;
        #2;
        chk++;
        if ({bus.busy, bus.done, bus.zero} !== 3'b001)
            $display("FAIL rst_mid_flags got busy=%b done=%b zero=%b exp 0 0 1",
                     bus.busy, bus.done, bus.zero);
        else pass++;
        chk++;
        if ({bus.hi, bus.lo} !== 64'd0)
            $display("FAIL rst_mid_prod got %h_%h exp 0", bus.hi, bus.lo);
        else pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL rst_discard got busy=%b done=%b exp 0 0",
                     bus.busy, bus.done);
        else pass++;
        launch(32'd5, 32'd5);
        wait_done(0, '0, '0);
        chk++;
        if (to || cyc != 33 || bus.lo !== 32'd25 || bus.zero !== 1'b0)
            $display("FAIL rst_rerun got cyc=%0d lo=%0d zero=%b exp 33 25 0",
                     cyc, bus.lo, bus.zero);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_busy_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
